// File: rtl/rx_mod_if.sv
// Receiver-side signal bundle for rx_mod: oversample tick, serial line,
// consumer acknowledge and the received-byte status outputs.
interface rx_mod_if;
  logic       tick;
  logic       rxd;
  logic       rx_ack;
  logic [7:0] dout;
  logic       rx_rdy;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  // The master side drives the line, the tick and the acknowledge.
  modport master (
    output tick, rxd, rx_ack,
    input  dout, rx_rdy, frame_err, overrun, busy
  );

  modport slave (
    input  tick, rxd, rx_ack,
    output dout, rx_rdy, frame_err, overrun, busy
  );
endinterface

// File: rtl/rx_mod.sv
// Oversampling UART receiver: 8N1 frames, mid-bit sampling, ready/overrun/
// frame-error status with acknowledge from the consumer.
module rx_mod #(
  parameter int OVERSAMPLE = 16
) (
  input logic     clk,
  input logic     rst,
  rx_mod_if.slave bus
);
  localparam int             CW      = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]  CNT_MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]  CNT_END = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state, state_nxt;
  logic          rxd_meta, rxs;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          done;

  // Synchronizer resets to the idle line level so no false start follows reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxs      <= 1'b1;
    end else begin
      rxd_meta <= bus.rxd;
      rxs      <= rxd_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    done        = 1'b0;
    if (bus.tick) begin
      cnt_nxt = (cnt == CNT_END) ? '0 : cnt + 1'b1;
      unique case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (!rxs) state_nxt = START;
        end
        START: begin
          if (cnt == CNT_MID) begin
            cnt_nxt     = '0;
            bit_idx_nxt = '0;
            state_nxt   = rxs ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt == CNT_END) begin
            shreg_nxt   = {rxs, shreg[7:1]};
            bit_idx_nxt = bit_idx + 1'b1;
            if (bit_idx == 3'd7) state_nxt = STOP;
          end
        end
        STOP: begin
          if (cnt == CNT_END) begin
            done      = 1'b1;
            state_nxt = rxs ? IDLE : WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          // A held-low line is a break, not a stream of zero bytes.
          if (rxs) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
    end
  end

  // A same-cycle ack consumes the previous byte, so it suppresses overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.dout      <= 8'h00;
      bus.rx_rdy    <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      if (done) begin
        bus.dout      <= shreg;
        bus.rx_rdy    <= 1'b1;
        bus.frame_err <= ~rxs;
        bus.overrun   <= bus.rx_rdy & ~bus.rx_ack;
      end else if (bus.rx_ack) begin
        bus.rx_rdy    <= 1'b0;
        bus.frame_err <= 1'b0;
        bus.overrun   <= 1'b0;
      end
      bus.busy <= (state_nxt != IDLE);
    end
  end
endmodule
